mod_instruction_fetch_ctrl: RTL

Instruction-fetch sequencer for mod_instruction_mem_rom. It owns the program counter, drives the ROM word address and captures each returned instruction into a registered fetch-output stage with valid/ready handshake. It also applies branch/jump redirects from execute and halts when the ROM reports end of program. It sits between the instruction ROM and the decode stage of the MIPS datapath.

---
 rtl/mod_instruction_fetch_ctrl_pkg.sv | 15 +
 rtl/mod_instruction_fetch_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/mod_instruction_fetch_ctrl_pkg.sv
// Shared fetch-sequencer definitions: state encodings and default widths,
// imported by fetch, decode and hazard logic alike.
package mod_instruction_fetch_ctrl_pkg;

  localparam int ADDR_W_DEF  = 30;
  localparam int INSTR_W_DEF = 32;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/mod_instruction_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, addresses the ROM and holds one
// fetched instruction in a valid/ready output register toward decode.
module mod_instruction_fetch_ctrl
  import mod_instruction_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  input  logic               rom_mem_end,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_t       state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic               vld_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [ADDR_W-1:0]  if_pc_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               free;

  assign free        = !if_valid || if_ready;
  assign rom_address = pc;
  assign halted      = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      pc             <= RESET_PC;
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
      fetch_count    <= '0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      if_valid       <= vld_nxt;
      if_instruction <= instr_nxt;
      if_pc          <= if_pc_nxt;
      fetch_count    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    vld_nxt   = if_valid;
    instr_nxt = if_instruction;
    if_pc_nxt = if_pc;
    cnt_nxt   = fetch_count;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
          pc_nxt    = RESET_PC;
        end
      end
      ST_FETCH: begin
        // Redirect wins over everything: the fetched word at pc is wrong-path.
        if (redirect_valid) begin
          pc_nxt  = redirect_addr;
          vld_nxt = 1'b0;
        end else if (free && rom_mem_end) begin
          state_nxt = ST_HALT;
          vld_nxt   = 1'b0;
        end else if (free) begin
          instr_nxt = rom_instruction;
          if_pc_nxt = pc;
          vld_nxt   = 1'b1;
          pc_nxt    = pc + ADDR_W'(1);
          if (fetch_count != '1) cnt_nxt = fetch_count + CNT_W'(1);
        end
      end
      ST_HALT: begin
        // A branch in the last drained instruction may restart fetch.
        if (redirect_valid) begin
          pc_nxt    = redirect_addr;
          vld_nxt   = 1'b0;
          state_nxt = ST_FETCH;
        end else if (if_valid && if_ready) begin
          vld_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
